// File: rtl/dec4_buf_if.sv
// Handshake bundle for dec4_buf: code-word producer side and decoded-line consumer side.
interface dec4_buf_if;
  logic       n1;
  logic       n2;
  logic       v;
  logic       in_valid;
  logic       in_ready;
  logic       d1;
  logic       d2;
  logic       d3;
  logic       d4;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] cnt;

  modport slave (
    input  n1, n2, v, in_valid, out_ready,
    output in_ready, d1, d2, d3, d4, out_valid, cnt
  );

  modport master (
    output n1, n2, v, in_valid, out_ready,
    input  in_ready, d1, d2, d3, d4, out_valid, cnt
  );
endinterface

// File: rtl/dec4_buf.sv
// 2-entry FIFO of {v,n2,n1} priority codes; the head word is decoded to one-hot d1..d4.
module dec4_buf (
  input  logic       clk,
  input  logic       rst,
  dec4_buf_if.slave  bus
);
  logic [2:0] mem_q [2];
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] occ_q, occ_d;
  logic [3:0] cnt_q, cnt_d;
  logic       in_ready, out_valid, push, pop;
  logic [2:0] head;
  logic [3:0] dec;

  // Flow control comes only from registered occupancy, so no ready->ready path.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;
  assign head      = mem_q[rptr_q];

  always_comb begin
    occ_d  = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
    cnt_d  = cnt_q + {3'b000, push};
  end

  always_comb begin
    dec = 4'b0000;
    if (out_valid && head[2]) begin
      case (head[1:0])
        2'b00:   dec = 4'b1000;
        2'b01:   dec = 4'b0100;
        2'b10:   dec = 4'b0010;
        default: dec = 4'b0001;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= 2'd0;
      cnt_q  <= 4'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage carries no reset; a write during reset is harmless since pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.v, bus.n2, bus.n1};
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.d1        = dec[3];
  assign bus.d2        = dec[2];
  assign bus.d3        = dec[1];
  assign bus.d4        = dec[0];
  assign bus.cnt       = cnt_q;
endmodule

// File: doc/dec4_buf.md
DEC4_BUF -- requirements
Module: dec4_buf

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high; ports `clk` and `rst`.
REQ-002 `clk`  input  1  rising-edge clock for all state.
REQ-003 `rst`  input  1  synchronous, active-high reset, sampled on the `clk` rising edge.
REQ-004 `n1`  input  1  code bit 0 of the incoming 2-bit priority code.
REQ-005 `n2`  input  1  code bit 1 of the incoming 2-bit priority code.
REQ-006 `v`  input  1  code-valid flag; 0 means no input line was active.
REQ-007 `in_valid`  input  1  producer presents {v,n2,n1} this cycle.
REQ-008 `in_ready`  output  1  block can accept a word this cycle.
REQ-009 `d1`, `d2`, `d3`, `d4`  output  1 each  one-hot decoded lines for the head word.
REQ-010 `out_valid`  output  1  `d1`..`d4` carry a buffered word.
REQ-011 `out_ready`  input  1  consumer takes the head word this cycle.
REQ-012 `cnt`  output  4  count of words accepted since reset, modulo 16.

Function
REQ-013 A push SHALL occur on a rising edge where `in_valid`=1 and `in_ready`=1; the block then stores {v,n2,n1}.
REQ-014 A pop SHALL occur on a rising edge where `out_valid`=1 and `out_ready`=1.
REQ-015 Storage SHALL be a 2-entry FIFO: two 3-bit entries, 1-bit write and read pointers, and a 2-bit occupancy 0..2.
REQ-016 `in_ready` SHALL be 1 exactly when occupancy < 2; it depends only on the registered occupancy, with no combinational path from `out_ready`.
REQ-017 `out_valid` SHALL be 1 exactly when occupancy > 0.
REQ-018 The head word SHALL decode as follows, with exactly one line high:
  - {n2,n1}=00 -> `d1`
  - 01 -> `d2`
  - 10 -> `d3`
  - 11 -> `d4`
REQ-019 A head word with v=0 SHALL drive `d1`..`d4`=0000 while `out_valid`=1; it is still a valid word and is popped normally.
REQ-020 When occupancy=0, `d1`..`d4` SHALL be 0000.
REQ-021 Latency SHALL be one cycle: a word pushed at edge N appears on `d1`..`d4` with `out_valid`=1 after edge N when the FIFO was empty.
REQ-022 No fall-through SHALL occur: `out_valid` is never asserted in the same cycle as the push of the word.
REQ-023 Occupancy transitions SHALL be:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
  - neither: unchanged
REQ-024 At occupancy 2, a pop SHALL be the only possible operation, since `in_ready`=0; the next cycle has occupancy 1 and `in_ready`=1.
REQ-025 At occupancy 0, `out_ready` SHALL be ignored.
REQ-026 Words SHALL leave in push order, and pointers wrap 1->0.
REQ-027 `cnt` SHALL increment by 1 on every push, wrapping 15->0, and is unaffected by pops.
REQ-028 Outputs SHALL not change while `out_valid`=1 and `out_ready`=0; the head word stays stable under backpressure.

Reset
REQ-029 When `rst`=1 at an edge, the block SHALL clear the pointers, occupancy and `cnt` to 0.
REQ-030 After reset, outputs SHALL be `in_ready`=1, `out_valid`=0, `d1`..`d4`=0000 and `cnt`=0.
REQ-031 `rst` SHALL take priority over a push or pop in the same cycle; buffered words are discarded and that push is not counted.
REQ-032 Entry contents need not be reset.

Verification
REQ-033 Single word with `out_ready`=1: after reset, push {v,n2,n1}=1,1,0 -> the next cycle shows `d3`=1, `out_valid`=1; the following cycle shows `out_valid`=0 and `cnt`=1.
REQ-034 Code sweep: push 100, 101, 110, 111, 000 with `out_ready`=1 -> `d1`..`d4` show 1000, 0100, 0010, 0001, 0000 in order, each with `out_valid`=1, and `cnt`=5.
REQ-035 Full FIFO: hold `out_ready`=0 and push 101 then 111 -> `in_ready`=0 with 101 held on the outputs (`d2`=1); a third `in_valid` is not accepted and `cnt`=2.
REQ-036 Drain from full:
  - raise `out_ready` for 1 cycle -> `d4`=1 shows and `in_ready`=1.
  - then push 100 while popping -> occupancy stays 1 and the order 111 then 100 is preserved.
REQ-037 Reset mid-operation: with 2 words buffered, assert `rst` together with `in_valid`=1 -> the next cycle shows `out_valid`=0, `d1`..`d4`=0000, `cnt`=0 and `in_ready`=1.
REQ-038 Counter wrap: 17 pushes -> `cnt`=1.
